// File: rtl/forth_pkg.sv
// Shared types and constants for the Forth program loader.
package forth_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        CSUM,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/forth_loader.sv
// Byte-stream loader: writes a framed image into instruction memory, then releases the core.
// Define FORTH_LOADER_CSUM_EN to require a trailing checksum byte on every frame.
//
// state   | meaning
// IDLE    | waiting for SYNC, discarding other bytes
// LEN_LO  | expecting word-count low byte
// LEN_HI  | expecting word-count high byte, bound check
// DATA_LO | expecting low byte of next word
// DATA_HI | expecting high byte, issues memory write
// CSUM    | expecting checksum byte (checksum builds only)
// DONE    | image loaded, core released, discarding until SYNC
// ERROR   | frame rejected, core held, discarding until SYNC
module forth_loader
    import forth_pkg::*;
#(
    parameter int                IM_WORDS = 256,
    parameter logic [BYTE_W-1:0] SYNC     = SYNC_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [BYTE_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic              ImWE,
    output logic [WORD_W-1:0] ImAddr,
    output logic [WORD_W-1:0] ImWData,
    output logic              CoreRst,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int IDX_W = $clog2(IM_WORDS) + 1;
    localparam logic [WORD_W:0] LEN_MAX = (WORD_W + 1)'(IM_WORDS);

`ifdef FORTH_LOADER_CSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t            state_q, state_n;
    logic [IDX_W-1:0]  index_q, index_n;
    logic [IDX_W-1:0]  len_q, len_n;
    logic [BYTE_W-1:0] len_lo_q, len_lo_n;
    logic [BYTE_W-1:0] lo_q, lo_n;
    logic              we_q, we_n;
    logic [WORD_W-1:0] addr_q, addr_n;
    logic [WORD_W-1:0] wdata_q, wdata_n;
    logic              core_rst_q, core_rst_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
`ifdef FORTH_LOADER_CSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_n;
`endif

    logic              accept;
    logic [WORD_W-1:0] full_len;
    logic [IDX_W-1:0]  index_inc;

    // A write cycle always stalls the byte port, so a byte can never race a write.
    assign InReady   = !we_q;
    assign accept    = InValid && !we_q;
    assign full_len  = {InData, len_lo_q};
    assign index_inc = index_q + IDX_W'(1);

    assign ImWE    = we_q;
    assign ImAddr  = addr_q;
    assign ImWData = wdata_q;
    assign CoreRst = core_rst_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Err     = err_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            len_q      <= '0;
            len_lo_q   <= '0;
            lo_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            index_q    <= index_n;
            len_q      <= len_n;
            len_lo_q   <= len_lo_n;
            lo_q       <= lo_n;
            we_q       <= we_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            core_rst_q <= core_rst_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

`ifdef FORTH_LOADER_CSUM_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_n;
        end
    end
`endif

    always_comb begin
        state_n    = state_q;
        index_n    = index_q;
        len_n      = len_q;
        len_lo_n   = len_lo_q;
        lo_n       = lo_q;
        we_n       = 1'b0;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        core_rst_n = core_rst_q;
        busy_n     = busy_q;
        done_n     = done_q;
        err_n      = err_q;
`ifdef FORTH_LOADER_CSUM_EN
        csum_n     = csum_q;
`endif

        if (accept) begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (InData == SYNC) begin
                        state_n    = LEN_LO;
                        done_n     = 1'b0;
                        err_n      = 1'b0;
                        busy_n     = 1'b1;
                        core_rst_n = 1'b1;
                    end
                end
                LEN_LO: begin
                    len_lo_n = InData;
                    state_n  = LEN_HI;
                end
                LEN_HI: begin
                    // Bounding LEN here is what keeps the word index from wrapping memory.
                    if (full_len == '0) begin
                        state_n = END_STATE;
                    end else if ({1'b0, full_len} > LEN_MAX) begin
                        state_n = ERROR;
                    end else begin
                        len_n   = full_len[IDX_W-1:0];
                        index_n = '0;
                        state_n = DATA_LO;
                    end
                end
                DATA_LO: begin
                    lo_n    = InData;
                    state_n = DATA_HI;
                end
                DATA_HI: begin
                    we_n    = 1'b1;
                    wdata_n = {InData, lo_q};
                    addr_n  = WORD_W'({index_q, 1'b0});
                    index_n = index_inc;
                    state_n = (index_inc == len_q) ? END_STATE : DATA_LO;
                end
`ifdef FORTH_LOADER_CSUM_EN
                CSUM: begin
                    state_n = (BYTE_W'(csum_q + InData) == '0) ? DONE : ERROR;
                end
`endif
                default: begin
                    state_n = ERROR;
                end
            endcase
        end

`ifdef FORTH_LOADER_CSUM_EN
        if (accept) begin
            if (state_q inside {IDLE, DONE, ERROR}) begin
                csum_n = '0;
            end else if (state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI}) begin
                csum_n = csum_q + InData;
            end
        end
`endif

        if (state_n == DONE && state_q != DONE) begin
            busy_n     = 1'b0;
            done_n     = 1'b1;
            core_rst_n = 1'b0;
        end
        if (state_n == ERROR && state_q != ERROR) begin
            busy_n     = 1'b0;
            err_n      = 1'b1;
            core_rst_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_forth_loader.sv
// Directed bench for forth_loader: scoreboarded memory writes plus handshake and status invariants.
module tb_forth_loader;
    import forth_pkg::*;

    localparam int IM_WORDS = 256;

    logic        Clk;
    logic        Rst;
    logic [7:0]  InData;
    logic        InValid;
    logic        InReady;
    logic        ImWE;
    logic [15:0] ImAddr;
    logic [15:0] ImWData;
    logic        CoreRst;
    logic        Busy;
    logic        Done;
    logic        Err;

    forth_loader #(.IM_WORDS(IM_WORDS), .SYNC(8'hA5)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .InData  (InData),
        .InValid (InValid),
        .InReady (InReady),
        .ImWE    (ImWE),
        .ImAddr  (ImAddr),
        .ImWData (ImWData),
        .CoreRst (CoreRst),
        .Busy    (Busy),
        .Done    (Done),
        .Err     (Err)
    );

    int          checks = 0;
    int          errors = 0;
    int          we_count = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [15:0] frame_words[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            chkb("ready_vs_we", InReady, !ImWE);
            chkb("corerst_vs_done", CoreRst, !Done);
            if (ImWE === 1'b1) begin
                we_count++;
                chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("write_addr_data", {ImAddr, ImWData}, exp_q.pop_front());
                end
            end
        end
    end

    // Presents one byte (called on a negedge) and returns on the negedge after it is accepted.
    task automatic send(input logic [7:0] b, input bit keep, input bit exp_we);
        int n = 0;
        InData  = b;
        InValid = 1'b1;
        while (InReady !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("ready_timeout", 32'(n < 20), 32'd1);
        @(negedge Clk);
        chkb("we_latency", ImWE, exp_we);
        if (!keep) InValid = 1'b0;
    endtask

    task automatic load(input int len, input bit stream, input bit bad_csum);
        logic [15:0] l;
        logic [15:0] w;
        logic [7:0]  sum;
        l   = 16'(len);
        sum = l[7:0] + l[15:8];
        send(8'hA5, stream, 1'b0);
        chkb("busy_after_sync", Busy, 1'b1);
        chkb("done_cleared", Done, 1'b0);
        chkb("err_cleared", Err, 1'b0);
        send(l[7:0], stream, 1'b0);
        send(l[15:8], stream, 1'b0);
        for (int i = 0; i < len; i++) begin
            w = frame_words[i];
            exp_q.push_back({16'(i * 2), w});
            sum = sum + w[7:0];
            sum = sum + w[15:8];
            send(w[7:0], stream, 1'b0);
            send(w[15:8], stream, 1'b1);
        end
`ifdef FORTH_LOADER_CSUM_EN
        send(bad_csum ? (8'(8'h00 - sum) ^ 8'h01) : 8'(8'h00 - sum), stream, 1'b0);
`endif
        InValid = 1'b0;
        @(negedge Clk);
        chkb("frame_done", Done, !bad_csum);
        chkb("frame_err", Err, bad_csum);
        chkb("frame_busy", Busy, 1'b0);
        chkb("frame_corerst", CoreRst, bad_csum);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_values();
        chkb("rst_inready", InReady, 1'b1);
        chkb("rst_imwe", ImWE, 1'b0);
        chk("rst_imaddr", 32'(ImAddr), 32'd0);
        chk("rst_imwdata", 32'(ImWData), 32'd0);
        chkb("rst_corerst", CoreRst, 1'b1);
        chkb("rst_busy", Busy, 1'b0);
        chkb("rst_done", Done, 1'b0);
        chkb("rst_err", Err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int          we_before;
        logic [15:0] big;

        Rst     = 1'b1;
        InData  = 8'h00;
        InValid = 1'b0;
        repeat (3) @(negedge Clk);
        chk_reset_values();
        Rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge Clk);

        // Reference two-word image.
        frame_words = '{16'h1234, 16'h5678};
        load(2, 1'b0, 1'b0);
        chk("two_word_writes", 32'(we_count), 32'd2);

        // Garbage bytes are dropped and Done stays sticky.
        we_before = we_count;
        send(8'h00, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h5A, 1'b0, 1'b0);
        chk("garbage_no_write", 32'(we_count), 32'(we_before));
        chkb("garbage_done_sticky", Done, 1'b1);
        frame_words = '{16'hBEEF, 16'h0001, 16'hCAFE};
        load(3, 1'b0, 1'b0);

        // Oversized LEN is rejected without touching memory.
        we_before = we_count;
        big = 16'(IM_WORDS + 1);
        send(8'hA5, 1'b0, 1'b0);
        send(big[7:0], 1'b0, 1'b0);
        send(big[15:8], 1'b0, 1'b0);
        chkb("oversize_err", Err, 1'b1);
        chkb("oversize_corerst", CoreRst, 1'b1);
        chkb("oversize_busy", Busy, 1'b0);
        chkb("oversize_done", Done, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        chk("oversize_no_write", 32'(we_count), 32'(we_before));
        frame_words = '{16'h0F0F};
        load(1, 1'b0, 1'b0);

        // Continuous InValid: stalls only during write cycles, scoreboard catches loss or dup.
        frame_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        load(4, 1'b1, 1'b0);

        // Reset mid-frame after the first data word.
        exp_q.push_back({16'h0000, 16'h2211});
        send(8'hA5, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b0);
        chkb("midframe_busy", Busy, 1'b1);
        Rst = 1'b1;
        #1;
        chk_reset_values();
        chk("midframe_first_word", 32'(exp_q.size()), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        frame_words = '{16'hA1B2, 16'hC3D4};
        load(2, 1'b0, 1'b0);

        // Empty image.
        we_before = we_count;
        load(0, 1'b0, 1'b0);
        chk("empty_no_write", 32'(we_count), 32'(we_before));

`ifdef FORTH_LOADER_CSUM_EN
        frame_words = '{16'h1234, 16'h5678};
        load(2, 1'b0, 1'b1);
        frame_words = '{16'h9ABC};
        load(1, 1'b1, 1'b0);
`endif

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
